// File: rtl/mul_share_arbiter_pkg.sv
// Shared state encoding and datapath widths for the multiplier-sharing arbiter.
package mul_share_arbiter_pkg;

   localparam int OP_W   = 8;
   localparam int PROD_W = 16;

   // Encoding 2'd3 is unused and steers back to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/mul_share_arbiter_if.sv
// Request/response bus between the client blocks and the shared multiplier.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both 1;
// the source holds valid and payload stable until that edge.
interface mul_share_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ*8-1:0] req_a;
   logic [NUM_REQ*8-1:0] req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [15:0]          rsp_data;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/mul_share_arbiter_mul.sv
// 8x8 unsigned multiplier built as a sum of shifted partial products.
module eight_bit_mul import mul_share_arbiter_pkg::*; (
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   output logic [PROD_W-1:0] mult
);
   always_comb begin
      mult = '0;
      for (int i = 0; i < OP_W; i++) begin
         if (b[i]) mult = mult + (PROD_W'(a) << i);
      end
   end
endmodule

// File: rtl/mul_share_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request after last_grant, wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant_onehot,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any
);
   logic found;
   int   idx;

   always_comb begin
      found        = 1'b0;
      idx          = 0;
      grant_idx    = '0;
      grant_onehot = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last_grant) + k) % NUM_REQ;
         if (!found && req[idx]) begin
            found     = 1'b1;
            grant_idx = ID_W'(idx);
         end
      end
      if (found && en) grant_onehot[grant_idx] = 1'b1;
      any = found & en;
   end
endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one eight_bit_mul among NUM_REQ requesters: round-robin grant, registered
// operands and result, IDLE -> CALC -> HOLD sequencing.
module mul_share_arbiter import mul_share_arbiter_pkg::*; #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                clk,
   input  logic                rst,
   mul_share_arbiter_if.slave  bus,
   output logic                busy,
   output logic [15:0]         done_count,
   output state_t              state
);
   state_t            next_state;
   logic [OP_W-1:0]   op_a, op_b, sel_a, sel_b;
   logic [ID_W-1:0]   id_q, last_grant, grant_idx;
   logic [PROD_W-1:0] mult;
   logic              any, en, accept;

   // Grant is only offered in IDLE and never while reset is asserted.
   assign en = (state == ST_IDLE) & ~rst;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req          (bus.req_valid),
      .last_grant   (last_grant),
      .en           (en),
      .grant_onehot (bus.req_ready),
      .grant_idx    (grant_idx),
      .any          (any)
   );

   eight_bit_mul u_mul (.a(op_a), .b(op_b), .mult(mult));

   assign sel_a = bus.req_a[OP_W*int'(grant_idx) +: OP_W];
   assign sel_b = bus.req_b[OP_W*int'(grant_idx) +: OP_W];
   assign busy  = (state != ST_IDLE);

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      case (state)
         ST_IDLE: if (any && |(bus.req_valid & bus.req_ready)) begin
            accept     = 1'b1;
            next_state = ST_CALC;
         end
         ST_CALC: next_state = ST_HOLD;
         ST_HOLD: if (bus.rsp_ready) next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         op_a         <= '0;
         op_b         <= '0;
         id_q         <= '0;
         last_grant   <= ID_W'(NUM_REQ - 1);
         bus.rsp_valid <= 1'b0;
         bus.rsp_id   <= '0;
         bus.rsp_data <= '0;
         done_count   <= '0;
      end else begin
         state <= next_state;
         if (accept) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            id_q       <= grant_idx;
            last_grant <= grant_idx;
         end
         if (state == ST_CALC) begin
            bus.rsp_data  <= mult;
            bus.rsp_id    <= id_q;
            bus.rsp_valid <= 1'b1;
         end
         if (state == ST_HOLD && bus.rsp_valid && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            done_count    <= done_count + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with an in-order response scoreboard.
module tb_mul_share_arbiter;
   import mul_share_arbiter_pkg::*;

   localparam int N  = 4;
   localparam int IW = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        busy;
   logic [15:0] done_count;
   state_t      state;
   int          checks = 0;
   int          errors = 0;
   logic [IW+15:0] exp_q[$];

   mul_share_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) bus();

   mul_share_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .busy       (busy),
      .done_count (done_count),
      .state      (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every response handshake pops one expected {id, data}.
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got id %0d data 0x%0h expected none", bus.rsp_id, bus.rsp_data);
         end else begin
            logic [IW+15:0] e;
            e = exp_q.pop_front();
            if ({bus.rsp_id, bus.rsp_data} !== e) begin
               errors++;
               $display("FAIL rsp: got id %0d data 0x%0h expected id %0d data 0x%0h",
                        bus.rsp_id, bus.rsp_data, e[IW+15:16], e[15:0]);
            end
         end
      end
   end

   task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.req_a[8*i +: 8] = a;
      bus.req_b[8*i +: 8] = b;
      bus.req_valid[i]    = 1'b1;
   endtask

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic issue(input int i, input logic [7:0] a, input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      set_req(i, a, b);
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         if (bus.req_ready[i]) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: got no req_ready for %0d expected accept", i);
      end
      @(posedge clk); #1;
      bus.req_valid[i] = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 60 && !ok; c++) begin
         @(negedge clk);
         if (!busy && exp_q.size() == 0) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got busy %0d pending %0d expected idle", busy, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      int accepts, last_acc, max_ones;
      bit seen;
      rst = 1'b1;
      bus.req_valid = '0;
      bus.req_a = '0;
      bus.req_b = '0;
      bus.rsp_ready = 1'b1;

      // Reset state, with every requester asserting valid.
      bus.req_valid = 4'b1111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(bus.req_ready), 32'h0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
      check("rst_rsp_data", 32'(bus.rsp_data), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done_count", 32'(done_count), 32'h0);
      check("rst_state", 32'(state), 32'(ST_IDLE));
      @(posedge clk); #1;
      bus.req_valid = '0;
      rst = 1'b0;
      @(posedge clk); #1;

      // 1: single op and two-clock latency
      exp_q.push_back({2'd0, 16'h9F60});
      issue(0, 8'hAA, 8'hF0);
      @(negedge clk);
      check("lat_calc_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      @(negedge clk);
      check("lat_hold_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      wait_idle();
      check("t1_done_count", 32'(done_count), 32'd1);

      // 2: back-to-back from different requesters
      exp_q.push_back({2'd2, 16'hFE01});
      issue(2, 8'hFF, 8'hFF);
      exp_q.push_back({2'd1, 16'h0000});
      issue(1, 8'h00, 8'h5A);
      wait_idle();
      check("t2_done_count", 32'(done_count), 32'd3);

      // 3: all valid after reset -> grants 0,1,2,3,0 three clocks apart
      do_reset();
      exp_q.push_back({2'd0, 16'h000F});
      exp_q.push_back({2'd1, 16'h0100});
      exp_q.push_back({2'd2, 16'h0100});
      exp_q.push_back({2'd3, 16'h4E20});
      exp_q.push_back({2'd0, 16'h000F});
      set_req(0, 8'h03, 8'h05);
      set_req(1, 8'h10, 8'h10);
      set_req(2, 8'h80, 8'h02);
      set_req(3, 8'hC8, 8'h64);
      accepts = 0;
      last_acc = 0;
      max_ones = 0;
      for (int c = 0; c < 60 && accepts < 5; c++) begin
         @(negedge clk);
         if ($countones(bus.req_ready) > max_ones) max_ones = $countones(bus.req_ready);
         if (|(bus.req_valid & bus.req_ready)) begin
            if (accepts > 0) check("issue_interval", 32'(c - last_acc), 32'd3);
            accepts++;
            last_acc = c;
         end
      end
      check("t3_accepts", 32'(accepts), 32'd5);
      check("t3_ready_onehot", 32'(max_ones), 32'd1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      wait_idle();
      check("t3_done_count", 32'(done_count), 32'd5);

      // 4: backpressure in HOLD with req3 waiting
      bus.rsp_ready = 1'b0;
      exp_q.push_back({2'd0, 16'h03A8});
      issue(0, 8'h12, 8'h34);
      exp_q.push_back({2'd3, 16'h003F});
      set_req(3, 8'h07, 8'h09);
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.rsp_valid) seen = 1'b1;
      end
      check("t4_rsp_valid", 32'(seen), 32'h1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         check("t4_hold_data", 32'(bus.rsp_data), 32'h03A8);
         check("t4_hold_id", 32'(bus.rsp_id), 32'd0);
         check("t4_hold_req_ready", 32'(bus.req_ready), 32'h0);
      end
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_handshake_req_ready", 32'(bus.req_ready), 32'h0);
      @(negedge clk);
      check("t4_req3_granted", 32'(bus.req_ready), 32'b1000);
      @(posedge clk); #1;
      bus.req_valid[3] = 1'b0;
      wait_idle();
      check("t4_done_count", 32'(done_count), 32'd7);

      // 5: reset mid-CALC discards the operation
      issue(1, 8'h05, 8'h06);
      rst = 1'b1;
      #2;
      check("t5_rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      check("t5_rst_done_count", 32'(done_count), 32'h0);
      check("t5_rst_busy", 32'(busy), 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.push_back({2'd0, 16'h0063});
      exp_q.push_back({2'd1, 16'h001E});
      set_req(0, 8'h21, 8'h03);
      set_req(1, 8'h05, 8'h06);
      @(negedge clk);
      check("t5_req0_wins", 32'(bus.req_ready), 32'b0001);
      @(posedge clk); #1;
      bus.req_valid[0] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk);
         if (bus.req_ready[1]) seen = 1'b1;
      end
      check("t5_req1_accept", 32'(seen), 32'h1);
      @(posedge clk); #1;
      bus.req_valid[1] = 1'b0;
      wait_idle();
      check("t5_done_count", 32'(done_count), 32'd2);

      // 6: done_count wrap
      force dut.done_count = 16'hFFFF;
      #1 release dut.done_count;
      @(negedge clk);
      check("t6_preload", 32'(done_count), 32'hFFFF);
      @(posedge clk); #1;
      exp_q.push_back({2'd2, 16'h00FF});
      issue(2, 8'h0F, 8'h11);
      wait_idle();
      check("t6_wrap", 32'(done_count), 32'h0);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
